decode: RTL and testbench

- Instruction-decode stage of the 5-stage pipelined RV64I core; sits between the IF/ID and ID/EX pipeline registers.
- Decodes the 32-bit instruction into control signals, register indices and a sign-extended 64-bit immediate, and registers them into the ID/EX stage.
- Performs load-use hazard detection: stalls PC and IF/ID, and injects a bubble into ID/EX.

---
 rtl/decode_if.sv | 60 ++++++
 rtl/decode.sv | 216 +++++++++++++++++++++
 tb/tb_decode.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/decode_if.sv
// ---------------------------------------------------------------------------
// decode_if : signal bundle between the IF/ID side, the decode stage and the
//             ID/EX register outputs of the RV64I pipeline.
//
// Signals:
//   instruction      32  instruction currently held in IF/ID
//   id_ex_MemRead     1  MemRead of the instruction now in EX
//   id_ex_Rd          5  destination register of the instruction now in EX
//   if_id_Rs1/Rs2     5  source registers of the IF/ID instruction
//   hazard_detected   1  external stall request
//   PCWrite           1  PC update enable (combinational)
//   IF_ID_Write       1  IF/ID write enable (combinational)
//   id_ex_*           ID/EX registered controls, register indices, valid bit
//   opcode            7  registered instr[6:0]
//   alu_src/alu_op/branch/imm  registered datapath controls and immediate
//
// Modports:
//   master : drives the IF/ID side inputs, observes the decode outputs
//   slave  : the decode stage itself
// ---------------------------------------------------------------------------
interface decode_if;
  logic [31:0] instruction;
  logic        id_ex_MemRead;
  logic [4:0]  id_ex_Rd;
  logic [4:0]  if_id_Rs1;
  logic [4:0]  if_id_Rs2;
  logic        hazard_detected;

  logic        PCWrite;
  logic        IF_ID_Write;
  logic        id_ex_Memread;
  logic        id_ex_MemtoReg;
  logic        id_ex_Regwrite;
  logic        id_ex_Memwrite;
  logic        id_ex_write;
  logic [4:0]  id_ex_rs1;
  logic [4:0]  id_ex_rs2;
  logic [4:0]  id_ex_rd;
  logic [6:0]  opcode;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic        branch;
  logic [63:0] imm;

  modport master (
    output instruction, id_ex_MemRead, id_ex_Rd, if_id_Rs1, if_id_Rs2,
           hazard_detected,
    input  PCWrite, IF_ID_Write, id_ex_Memread, id_ex_MemtoReg,
           id_ex_Regwrite, id_ex_Memwrite, id_ex_write, id_ex_rs1,
           id_ex_rs2, id_ex_rd, opcode, alu_src, alu_op, branch, imm
  );

  modport slave (
    input  instruction, id_ex_MemRead, id_ex_Rd, if_id_Rs1, if_id_Rs2,
           hazard_detected,
    output PCWrite, IF_ID_Write, id_ex_Memread, id_ex_MemtoReg,
           id_ex_Regwrite, id_ex_Memwrite, id_ex_write, id_ex_rs1,
           id_ex_rs2, id_ex_rd, opcode, alu_src, alu_op, branch, imm
  );
endinterface

// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode : instruction-decode stage of the 5-stage RV64I pipeline.
//
// Decodes the IF/ID instruction into control bits, register indices and a
// sign-extended 64-bit immediate, and registers them into ID/EX. Detects
// stalls (external request, optionally load-use) and turns the ID/EX entry
// into a bubble while holding PC and IF/ID.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears every ID/EX output
//   bus    decode_if.slave : IF/ID side inputs and ID/EX outputs
//
// Build option:
//   LOAD_USE_DETECT_EN  when defined, a load in EX whose rd (non-zero)
//                       matches rs1/rs2 of the IF/ID instruction stalls.
//                       When undefined, only hazard_detected stalls.
// ---------------------------------------------------------------------------
module decode (
  input  logic     clk,
  input  logic     reset,
  decode_if.slave  bus
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // ID/EX contents; controls are grouped so a bubble clears them together
  typedef struct packed {
    logic        memread;
    logic        memtoreg;
    logic        regwrite;
    logic        memwrite;
    logic        alu_src;
    logic        branch;
    logic        valid;
    logic [3:0]  alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [63:0] imm;
  } idex_t;

  function automatic logic [63:0] imm_i(input logic [31:0] ins);
    return {{52{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [63:0] imm_s(input logic [31:0] ins);
    return {{52{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [63:0] imm_b(input logic [31:0] ins);
    return {{52{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [63:0] imm_u(input logic [31:0] ins);
    return {{32{ins[31]}}, ins[31:12], 12'b0};
  endfunction

  function automatic logic [63:0] imm_j(input logic [31:0] ins);
    return {{44{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  // funct3 -> ALU op; instr[30] picks SUB (R-type only) and SRA (both)
  function automatic logic [3:0] alu_sel(input logic [2:0] f3,
                                         input logic       b30,
                                         input logic       is_r);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_r && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic        load_use_s;
  logic        stall_s;
  ctrl_t       dec_ctrl_s;
  logic [63:0] dec_imm_s;
  idex_t       idex_d;
  idex_t       idex_q;
  logic [31:0] ins_s;

  assign ins_s = bus.instruction;

`ifdef LOAD_USE_DETECT_EN
  assign load_use_s = bus.id_ex_MemRead && (bus.id_ex_Rd != 5'd0) &&
                      ((bus.id_ex_Rd == bus.if_id_Rs1) ||
                       (bus.id_ex_Rd == bus.if_id_Rs2));
`else
  // Detection disabled: the compare inputs are still read so both builds
  // have the same port usage, but the result is forced to 0.
  assign load_use_s = 1'b0 & (^{bus.id_ex_MemRead, bus.id_ex_Rd,
                                bus.if_id_Rs1, bus.if_id_Rs2});
`endif

  assign stall_s         = bus.hazard_detected | load_use_s;
  assign bus.PCWrite     = ~stall_s;
  assign bus.IF_ID_Write = ~stall_s;

  // Opcode decode into controls and immediate
  always_comb begin
    dec_ctrl_s = '0;
    dec_imm_s  = 64'd0;
    case (ins_s[6:0])
      OP_R: begin
        dec_ctrl_s.regwrite = 1'b1;
        dec_ctrl_s.valid    = 1'b1;
        dec_ctrl_s.alu_op   = alu_sel(ins_s[14:12], ins_s[30], 1'b1);
      end
      OP_I: begin
        dec_ctrl_s.regwrite = 1'b1;
        dec_ctrl_s.alu_src  = 1'b1;
        dec_ctrl_s.valid    = 1'b1;
        dec_ctrl_s.alu_op   = alu_sel(ins_s[14:12], ins_s[30], 1'b0);
        dec_imm_s           = imm_i(ins_s);
      end
      OP_LOAD: begin
        dec_ctrl_s.memread  = 1'b1;
        dec_ctrl_s.memtoreg = 1'b1;
        dec_ctrl_s.regwrite = 1'b1;
        dec_ctrl_s.alu_src  = 1'b1;
        dec_ctrl_s.valid    = 1'b1;
        dec_ctrl_s.alu_op   = ALU_ADD;
        dec_imm_s           = imm_i(ins_s);
      end
      OP_STORE: begin
        dec_ctrl_s.memwrite = 1'b1;
        dec_ctrl_s.alu_src  = 1'b1;
        dec_ctrl_s.valid    = 1'b1;
        dec_ctrl_s.alu_op   = ALU_ADD;
        dec_imm_s           = imm_s(ins_s);
      end
      OP_BR: begin
        dec_ctrl_s.branch   = 1'b1;
        dec_ctrl_s.valid    = 1'b1;
        dec_ctrl_s.alu_op   = ALU_SUB;
        dec_imm_s           = imm_b(ins_s);
      end
      // Unsupported formats: no controls, but the immediate is still shown
      OP_LUI, OP_AUIPC: dec_imm_s = imm_u(ins_s);
      OP_JAL:           dec_imm_s = imm_j(ins_s);
      OP_JALR:          dec_imm_s = imm_i(ins_s);
      default:          dec_imm_s = 64'd0;
    endcase
  end

  // ID/EX next state: fields always load, controls become a bubble on stall
  always_comb begin
    idex_d        = '0;
    idex_d.rs1    = ins_s[19:15];
    idex_d.rs2    = ins_s[24:20];
    idex_d.rd     = ins_s[11:7];
    idex_d.opcode = ins_s[6:0];
    idex_d.imm    = dec_imm_s;
    if (stall_s) begin
      idex_d.ctrl = '0;
    end else begin
      idex_d.ctrl = dec_ctrl_s;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign bus.id_ex_Memread  = idex_q.ctrl.memread;
  assign bus.id_ex_MemtoReg = idex_q.ctrl.memtoreg;
  assign bus.id_ex_Regwrite = idex_q.ctrl.regwrite;
  assign bus.id_ex_Memwrite = idex_q.ctrl.memwrite;
  assign bus.alu_src        = idex_q.ctrl.alu_src;
  assign bus.branch         = idex_q.ctrl.branch;
  assign bus.id_ex_write    = idex_q.ctrl.valid;
  assign bus.alu_op         = idex_q.ctrl.alu_op;
  assign bus.id_ex_rs1      = idex_q.rs1;
  assign bus.id_ex_rs2      = idex_q.rs2;
  assign bus.id_ex_rd       = idex_q.rd;
  assign bus.opcode         = idex_q.opcode;
  assign bus.imm            = idex_q.imm;

endmodule

// File: tb/tb_decode.sv
// ---------------------------------------------------------------------------
// tb_decode : self-checking bench for the decode stage. Directed cases from
// the instruction set plus randomized instructions and stall inputs, checked
// against a reference model computed from the ISA rules.
// ---------------------------------------------------------------------------
module tb_decode;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  decode_if bus ();

  decode dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected ID/EX view; ctrl = {Memread,MemtoReg,Regwrite,Memwrite,alu_src,branch,write}
  typedef struct {
    logic [6:0]  ctrl;
    logic [3:0]  alu;
    logic [14:0] regs;
    logic [6:0]  op;
    logic [63:0] imm;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_stall(input logic hz, input logic mr,
                                       input logic [4:0] rd,
                                       input logic [4:0] r1, input logic [4:0] r2);
    logic lu;
    lu = 1'b0;
`ifdef LOAD_USE_DETECT_EN
    lu = mr && (rd != 5'd0) && (rd == r1 || rd == r2);
`endif
    return hz || lu;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic stall);
    exp_t e;
    logic [3:0] tab [8];
    int f3;
    longint v;
    // funct3 -> ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND
    tab[0] = 4'd0; tab[1] = 4'd5; tab[2] = 4'd8; tab[3] = 4'd9;
    tab[4] = 4'd4; tab[5] = 4'd6; tab[6] = 4'd3; tab[7] = 4'd2;
    f3 = int'(ins[14:12]);
    e.ctrl = 7'd0;
    e.alu  = 4'd0;
    v      = 0;
    e.regs = {ins[19:15], ins[24:20], ins[11:7]};
    e.op   = ins[6:0];
    case (ins[6:0])
      7'h33: begin
        e.ctrl = 7'b0010001; e.alu = tab[f3];
        if (f3 == 0 && ins[30]) e.alu = 4'd1;
        if (f3 == 5 && ins[30]) e.alu = 4'd7;
      end
      7'h13: begin
        e.ctrl = 7'b0010101; e.alu = tab[f3];
        if (f3 == 5 && ins[30]) e.alu = 4'd7;
        v = longint'($signed(ins[31:20]));
      end
      7'h03: begin e.ctrl = 7'b1110101; v = longint'($signed(ins[31:20])); end
      7'h23: begin e.ctrl = 7'b0001101; v = longint'($signed({ins[31:25], ins[11:7]})); end
      7'h63: begin
        e.ctrl = 7'b0000011; e.alu = 4'd1;
        v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
      end
      7'h37, 7'h17: v = longint'($signed(ins[31:12])) * 4096;
      7'h6F: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
      7'h67: v = longint'($signed(ins[31:20]));
      default: v = 0;
    endcase
    e.imm = 64'(v);
    if (stall) begin
      e.ctrl = 7'd0;
      e.alu  = 4'd0;
    end
    return e;
  endfunction

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".ctrl"}, {57'd0, bus.id_ex_Memread, bus.id_ex_MemtoReg, bus.id_ex_Regwrite,
                         bus.id_ex_Memwrite, bus.alu_src, bus.branch, bus.id_ex_write},
        {57'd0, e.ctrl});
    chk({tag, ".alu_op"}, {60'd0, bus.alu_op}, {60'd0, e.alu});
    chk({tag, ".regs"}, {49'd0, bus.id_ex_rs1, bus.id_ex_rs2, bus.id_ex_rd}, {49'd0, e.regs});
    chk({tag, ".opcode"}, {57'd0, bus.opcode}, {57'd0, e.op});
    chk({tag, ".imm"}, bus.imm, e.imm);
  endtask

  // Drive one instruction at the negedge, check the stall outputs, clock it
  // into ID/EX and check the registered view at the following negedge.
  task automatic step(input string tag, input logic [31:0] ins, input logic hz,
                      input logic mr, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic st;
    exp_t e;
    bus.instruction     = ins;
    bus.hazard_detected = hz;
    bus.id_ex_MemRead   = mr;
    bus.id_ex_Rd        = rd;
    bus.if_id_Rs1       = r1;
    bus.if_id_Rs2       = r2;
    st = model_stall(hz, mr, rd, r1, r2);
    e  = model(ins, st);
    #1;
    chk({tag, ".PCWrite"}, {63'd0, bus.PCWrite}, {63'd0, ~st});
    chk({tag, ".IF_ID_Write"}, {63'd0, bus.IF_ID_Write}, {63'd0, ~st});
    @(posedge clk);
    @(negedge clk);
    chk_out(tag, e);
  endtask

  initial begin
    exp_t zero_e;
    logic [6:0] ops [10];
    n_checks = 0;
    n_errors = 0;
    zero_e.ctrl = 7'd0; zero_e.alu = 4'd0; zero_e.regs = 15'd0;
    zero_e.op = 7'd0; zero_e.imm = 64'd0;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h63;
    ops[5] = 7'h37; ops[6] = 7'h17; ops[7] = 7'h6F; ops[8] = 7'h67; ops[9] = 7'h0F;

    reset = 1'b1;
    bus.instruction     = 32'h002081B3;
    bus.hazard_detected = 1'b0;
    bus.id_ex_MemRead   = 1'b0;
    bus.id_ex_Rd        = 5'd0;
    bus.if_id_Rs1       = 5'd0;
    bus.if_id_Rs2       = 5'd0;
    repeat (2) @(negedge clk);
    chk_out("reset", zero_e);
    reset = 1'b0;

    // Directed decode cases
    step("add",  32'h002081B3, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("add.write", {63'd0, bus.id_ex_write}, 64'd1);
    step("addi", 32'h00508193, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("addi.imm", bus.imm, 64'd5);
    step("lw",   32'h0040A183, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("lw.imm", bus.imm, 64'd4);
    step("sw",   32'h0030A223, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("sw.rs2", {59'd0, bus.id_ex_rs2}, 64'd3);
    step("beq",  32'h001101E3, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("beq.imm", bus.imm, 64'd2050);
    step("sub",  32'h402081B3, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("sub.alu_op", {60'd0, bus.alu_op}, 64'd1);
    step("srai", 32'h4030D193, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("srai.alu_op", {60'd0, bus.alu_op}, 64'd7);

    // External stall and release
    step("hazard", 32'h002081B3, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("hazard.write", {63'd0, bus.id_ex_write}, 64'd0);
    step("resume", 32'h002081B3, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

    // Load-use compares (stall only in the detecting build)
    step("lu_hit",  32'h002081B3, 1'b0, 1'b1, 5'd5, 5'd5, 5'd9);
    step("lu_rs2",  32'h002081B3, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7);
    step("lu_rd0",  32'h002081B3, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    step("lu_nomr", 32'h002081B3, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5);

    // Asynchronous reset mid-run, between edges
    step("pre_rst", 32'h00508193, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #2;
    reset = 1'b1;
    #1;
    chk_out("midrst", zero_e);
    chk("midrst.PCWrite", {63'd0, bus.PCWrite}, 64'd1);
    chk("midrst.IF_ID_Write", {63'd0, bus.IF_ID_Write}, 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // Randomized instructions and stall inputs
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      logic [4:0]  rd;
      ins      = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      rd       = 5'($urandom_range(0, 3));
      step("rand", ins, ($urandom_range(0, 7) == 0), 1'($urandom),
           rd, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
